// File: rtl/add32_seq.sv
// add32_seq: 32-bit add/sub over eight steps of one shared cla4 slice; ADD32_SEQ_SUB_EN enables subtract
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | p[0] & ci;
  assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & ci;
  assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & ci;
  assign c[4] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
              | p[3] & p[2] & p[1] & p[0] & ci;
  assign s  = p ^ c[3:0];
  assign co = c[4];
endmodule

module add32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        co,
  output logic        ovf
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_n;
  logic [31:0] a_r, b_r;
  logic        c_r, sub, nc;
  logic [2:0]  cnt;
  logic [4:0]  base;
  logic [3:0]  ns;
`ifdef ADD32_SEQ_SUB_EN
  assign sub = op_sub;
`else
  assign sub = op_sub & 1'b0;
`endif
  assign base = {cnt, 2'b00};
  cla4 u_cla4 (.a(a_r[base+:4]), .b(b_r[base+:4]), .ci(c_r), .s(ns), .co(nc));
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = CALC;
    if (state == CALC && cnt == 3'd7) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      s    <= '0;
      co   <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_r  <= a;
          b_r  <= sub ? ~b : b;
          c_r  <= sub;
          cnt  <= '0;
          busy <= 1'b1;
        end
      end else begin
        s[base+:4] <= ns;
        c_r        <= nc;
        cnt        <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          co   <= nc;
          ovf  <= (a_r[31] == b_r[31]) & (ns[3] != a_r[31]);
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_add32_seq.sv
// tb_add32_seq: scoreboard bench for add32_seq
module tb_add32_seq;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, op_sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, co, ovf;
  logic [31:0] s;
  logic [33:0] exp_q[$];
  int vectors = 0, miscompares = 0;

  add32_seq dut (.clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
                 .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf));

  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic eff;
    logic [31:0] yy;
    logic [32:0] r;
`ifdef ADD32_SEQ_SUB_EN
    eff = sub;
`else
    eff = 1'b0;
`endif
    yy = eff ? ~y : y;
    r = {1'b0, x} + {1'b0, yy} + {32'd0, eff};
    return {r[31:0], r[32], (x[31] == yy[31]) && (r[31] != x[31])};
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sub, input logic push);
    @(posedge clk);
    #1 start = 1'b1; a = x; b = y; op_sub = sub;
    if (push) exp_q.push_back(model(x, y, sub));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (busy) bc++;
    end while (!done && lat < 20);
  endtask

  function automatic logic [33:0] pop_exp();
    return exp_q.size() > 0 ? exp_q.pop_front() : 34'h0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, s, co, ovf} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b done=%b s=%h co=%b ovf=%b, need all zero", busy, done, s, co, ovf);
    end
  endtask

  task automatic test_add();
    logic [31:0] ta[8] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h1, 32'hA5A5A5A5, 32'h80000000};
    logic [31:0] tb[8] = '{32'h1, 32'h1, 32'h0, 32'h21524111, 32'hF0F0F0F1, 32'h2, 32'h5A5A5A5B, 32'h80000000};
    int lat, bc;
    logic b0;
    logic [33:0] e;
    ta[5] = $urandom; tb[5] = $urandom;
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i], 1'b0, 1'b1);
      b0 = busy;
      wait_done(lat, bc);
      e = pop_exp();
      vectors++;
      if (lat != 8 || bc + int'(b0) != 8 || {s, co, ovf} !== e) begin
        miscompares++;
        $display("FAIL add %h+%h: got lat=%0d busy=%0d s=%h co=%b ovf=%b, need lat=8 busy=8 s=%h co=%b ovf=%b",
                 ta[i], tb[i], lat, bc + int'(b0), s, co, ovf, e[33:2], e[1], e[0]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse: got done=%b, need 0", done);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta[2] = '{32'd5, 32'd7};
    logic [31:0] tb[2] = '{32'd7, 32'd5};
    int lat, bc;
    logic [33:0] e;
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 1'b1, 1'b1);
      wait_done(lat, bc);
      e = pop_exp();
      vectors++;
      if (lat != 8 || {s, co, ovf} !== e) begin
        miscompares++;
        $display("FAIL sub %0d-%0d: got lat=%0d s=%h co=%b ovf=%b, need lat=8 s=%h co=%b ovf=%b",
                 ta[i], tb[i], lat, s, co, ovf, e[33:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int nd = 0, dl = 0;
    logic [33:0] got = '0, e;
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b1);
    for (int lat = 1; lat <= 12; lat++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        dl = lat;
        got = {s, co, ovf};
      end
      start = (lat == 2 || lat == 5);
      if (start) begin
        a = $urandom; b = $urandom; op_sub = 1'b1;
      end
    end
    e = pop_exp();
    vectors++;
    if (nd != 1 || dl != 8 || got !== e) begin
      miscompares++;
      $display("FAIL ignore_start: got dones=%0d lat=%0d res=%h, need dones=1 lat=8 res=%h", nd, dl, got, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic b0;
    logic [33:0] e;
    issue(32'hCAFEF00D, 32'h13572468, 1'b0, 1'b1);
    wait_done(lat, bc);
    e = pop_exp();
    vectors++;
    if (lat != 8 || {s, co, ovf} !== e) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d res=%h, need lat=8 res=%h", lat, {s, co, ovf}, e);
    end
    start = 1'b1; a = 32'h89ABCDEF; b = 32'h76543210; op_sub = 1'b0;
    exp_q.push_back(model(a, b, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    b0 = busy;
    wait_done(lat, bc);
    e = pop_exp();
    vectors++;
    if (b0 !== 1'b1 || lat != 8 || {s, co, ovf} !== e) begin
      miscompares++;
      $display("FAIL b2b_second: got busy=%b lat=%0d res=%h, need busy=1 lat=8 res=%h", b0, lat, {s, co, ovf}, e);
    end
  endtask

  task automatic test_midreset();
    int nd = 0, lat, bc;
    logic [33:0] e;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    vectors++;
    if ({busy, s, co, ovf} !== 34'd0) begin
      miscompares++;
      $display("FAIL midreset: got busy=%b s=%h co=%b ovf=%b, need all zero", busy, s, co, ovf);
    end
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    vectors++;
    if (nd != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got %0d active cycles, need 0", nd);
    end
    issue(32'd1, 32'd2, 1'b0, 1'b1);
    wait_done(lat, bc);
    e = pop_exp();
    vectors++;
    if (lat != 8 || {s, co, ovf} !== e) begin
      miscompares++;
      $display("FAIL after_reset 1+2: got lat=%0d s=%h, need lat=8 s=%h", lat, s, e[33:2]);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_add();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
